// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the scpu pipeline flush/stall control.
// Also holds the fixed-priority redirect select.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    CAUSE_BRJ  = 2'd0,
    CAUSE_SRET = 2'd1,
    CAUSE_MRET = 2'd2,
    CAUSE_TRAP = 2'd3
  } cause_e;

  // Instruction the IF NOP mux substitutes for a killed fetch (addi x0,x0,0).
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_e;

  typedef struct packed {
    logic        valid;
    cause_e      cause;
    logic [31:0] target;
  } redirect_t;

  // Fixed priority: trap > mret > sret > branch/jump.
  function automatic redirect_t select_redirect(
    input logic        is_trap,
    input logic        is_mret,
    input logic        is_sret,
    input logic        is_branch_jump,
    input logic [31:0] trap_pc,
    input logic [31:0] mepc,
    input logic [31:0] sepc,
    input logic [31:0] branch_pc
  );
    redirect_t r;
    r.valid = is_trap | is_mret | is_sret | is_branch_jump;
    if (is_trap) begin
      r.cause  = CAUSE_TRAP;
      r.target = trap_pc;
    end else if (is_mret) begin
      r.cause  = CAUSE_MRET;
      r.target = mepc;
    end else if (is_sret) begin
      r.cause  = CAUSE_SRET;
      r.target = sepc;
    end else if (is_branch_jump) begin
      r.cause  = CAUSE_BRJ;
      r.target = branch_pc;
    end else begin
      r.cause  = CAUSE_BRJ;
      r.target = 32'h0;
    end
    return r;
  endfunction

endpackage

// File: rtl/fetch_inflight_cnt.sv
// Saturating count of outstanding IMEM fetches, fetch-issue permission,
// and the number of fetches still owed to the IF stage after this cycle.
module fetch_inflight_cnt #(
  parameter int MAX_INFLIGHT = 2,
  parameter int CNT_W        = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_fire,
  input  logic             resp_valid,
  input  logic             stall,
  output logic [CNT_W-1:0] pend,
  output logic             req_allow
);

  localparam logic [CNT_W:0] MAX_W = (CNT_W+1)'(MAX_INFLIGHT);

  logic [CNT_W-1:0] inflight;
  logic             resp_eff;
  logic [CNT_W:0]   sum;

  // A response with nothing outstanding is spurious and must not underflow.
  assign resp_eff = resp_valid && (inflight != '0);

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    sum = {1'b0, inflight} + {{CNT_W{1'b0}}, req_fire} - {{CNT_W{1'b0}}, resp_eff};
    if (sum > MAX_W) begin
      sum = MAX_W;
    end
  end

  // pend equals the next counter value: fetches older than any redirect seen now.
  assign pend = sum[CNT_W-1:0];

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      inflight <= pend;
    end
  end

  assign req_allow = rst || (({1'b0, inflight} < MAX_W) && !stall);

endmodule

// File: rtl/pipe_flush_ctrl.sv
// Central flush/stall sequencer: MEM-resolved redirects, ID load-use stalls,
// and the kill window for stale fetch responses after a redirect.
module pipe_flush_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_INFLIGHT = 2,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_is_trap,
  input  logic        mem_is_mret,
  input  logic        mem_is_sret,
  input  logic        mem_is_branch_jump,
  input  logic [31:0] trap_pc,
  input  logic [31:0] mepc,
  input  logic [31:0] sepc,
  input  logic [31:0] branch_pc,
  input  logic        id_load_use,
  input  logic        imem_req_fire,
  input  logic        imem_resp_valid,
  output logic        imem_req_allow,
  output logic        if_kill,
  output logic        id_flush,
  output logic        ex_flush,
  output logic        if_stall,
  output logic        pc_redirect_valid,
  output logic [31:0] pc_redirect_target,
  output logic [1:0]  redirect_cause,
  output logic        draining
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state, state_nxt;
  logic [CNT_W-1:0] drop_cnt, drop_nxt;
  logic [CNT_W-1:0] pend;
  redirect_t        redir_sel;
  logic             redir;
  logic             load_stall;

  assign redir_sel = select_redirect(mem_is_trap, mem_is_mret, mem_is_sret, mem_is_branch_jump,
                                     trap_pc, mepc, sepc, branch_pc);
  assign redir      = redir_sel.valid;
  // A redirect flushes ID anyway, so the load-use stall is dropped.
  assign load_stall = id_load_use && !redir;

  fetch_inflight_cnt #(
    .MAX_INFLIGHT (MAX_INFLIGHT),
    .CNT_W        (CNT_W)
  ) u_inflight (
    .clk        (clk),
    .rst        (rst),
    .req_fire   (imem_req_fire),
    .resp_valid (imem_resp_valid),
    .stall      (load_stall),
    .pend       (pend),
    .req_allow  (imem_req_allow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      drop_cnt <= '0;
    end else begin
      state    <= state_nxt;
      drop_cnt <= drop_nxt;
    end
  end

  // A later redirect always restarts the drop window with its own pend.
  always_comb begin
    state_nxt = state;
    drop_nxt  = drop_cnt;
    if (redir) begin
      drop_nxt  = pend;
      state_nxt = (pend != '0) ? DRAIN : RUN;
    end else if (state == DRAIN && imem_resp_valid) begin
      if (drop_cnt <= CNT_ONE) begin
        drop_nxt  = '0;
        state_nxt = RUN;
      end else begin
        drop_nxt  = drop_cnt - CNT_ONE;
      end
    end
  end

  always_comb begin
    if_kill            = 1'b0;
    id_flush           = 1'b0;
    ex_flush           = 1'b0;
    if_stall           = 1'b0;
    pc_redirect_valid  = 1'b0;
    pc_redirect_target = 32'h0;
    redirect_cause     = 2'd0;
    draining           = 1'b0;
    if (!rst) begin
      if_kill           = imem_resp_valid && (redir || state == DRAIN);
      id_flush          = redir;
      ex_flush          = redir || id_load_use;
      if_stall          = load_stall;
      pc_redirect_valid = redir;
      draining          = (state == DRAIN);
      if (redir) begin
        pc_redirect_target = redir_sel.target;
        redirect_cause     = redir_sel.cause;
      end
    end
  end

endmodule

// File: doc/pipe_flush_ctrl.md
Name: pipe_flush_ctrl

Overview:
- Central flush/stall sequencer for the five-stage scpu pipeline.
- Takes redirect events resolved in MEM (trap, mret, sret, branch/jump) and the ID load-use hazard.
- Drives the IF-stage NOP-substitution select, per-stage flush/stall, and the PC redirect.
- Tracks in-flight instruction fetches and kills stale fetch responses after a redirect until the fetch stream is clean.

Parameters:
- MAX_INFLIGHT, 2, maximum outstanding IMEM fetch requests (1..7).
- CNT_W, 3, width of the in-flight and drop counters; must hold MAX_INFLIGHT.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- mem_is_trap  in  1  MEM-stage instruction traps
- mem_is_mret  in  1  MEM-stage mret
- mem_is_sret  in  1  MEM-stage sret
- mem_is_branch_jump  in  1  MEM-stage taken branch or jump
- trap_pc  in  32  trap vector target
- mepc  in  32  mret target
- sepc  in  32  sret target
- branch_pc  in  32  branch/jump target
- id_load_use  in  1  ID depends on a load currently in EX
- imem_req_fire  in  1  fetch request accepted this cycle
- imem_resp_valid  in  1  fetch response arrives this cycle
- imem_req_allow  out  1  IF may issue a fetch (in-flight < MAX_INFLIGHT)
- if_kill  out  1  select for the IF NOP mux; response becomes 32'h13
- id_flush  out  1  turn ID into a bubble
- ex_flush  out  1  turn EX into a bubble
- if_stall  out  1  hold PC and IF/ID
- pc_redirect_valid  out  1  load pc_redirect_target into PC
- pc_redirect_target  out  32  new PC
- redirect_cause  out  2  0 = branch/jump, 1 = sret, 2 = mret, 3 = trap
- draining  out  1  FSM is in DRAIN

Behaviour:
- Reset: synchronous on rst high. FSM = RUN; inflight = 0; drop_cnt = 0. All registered state clears the same edge.
- Reset mid-DRAIN abandons the drain with no kill.
- With rst high, every output is 0 except imem_req_allow = 1. pc_redirect_target is 0.
- Redirect select uses fixed priority trap > mret > sret > branch_jump. redir = OR of the four event inputs.
- Redirect outputs are combinational, same cycle as redir:
  - pc_redirect_valid = 1
  - target and cause follow the priority select
  - id_flush = 1, ex_flush = 1
  - if_kill = 1 if imem_resp_valid in that cycle
- inflight counter:
  - +1 on imem_req_fire, -1 on imem_resp_valid; both in one cycle leaves it unchanged.
  - Saturates at MAX_INFLIGHT. A response with inflight = 0 is ignored (no underflow).
  - imem_req_allow = (inflight < MAX_INFLIGHT) && !if_stall.
- FSM RUN:
  - On redir, compute pend = inflight - imem_resp_valid + imem_req_fire. This counts fetches issued before the redirect took effect.
  - pend > 0: drop_cnt <= pend, go to DRAIN.
  - pend = 0: stay in RUN.
- FSM DRAIN:
  - Each imem_resp_valid asserts if_kill and decrements drop_cnt.
  - When drop_cnt reaches 0 on that response, go to RUN next cycle.
  - New fetches issued in DRAIN belong to the redirected stream and are not counted in drop_cnt.
  - draining = 1 in DRAIN.
- redir while in DRAIN: drop_cnt is reloaded with the freshly computed pend; the later redirect wins. Stay in DRAIN, or go to RUN if pend = 0.
- Load-use: with id_load_use and no redir:
  - if_stall = 1, ex_flush = 1 (bubble), id_flush = 0.
  - Response arriving under stall is not killed. IF holds it.
- redir and id_load_use together: the flush wins, if_stall = 0.
- Latency:
  - Redirect takes effect at the next clock edge (PC loaded).
  - First correct instruction is fetched the cycle after the redirect.
  - Stale responses are killed for exactly pend responses.

Decomposition:
- Shared package (pipe_ctrl_pkg):
  - redirect cause encodings (CAUSE_BRJ = 0, CAUSE_SRET = 1, CAUSE_MRET = 2, CAUSE_TRAP = 3)
  - NOP_INST = 32'h13
  - FSM state enum {RUN, DRAIN}
- One natural sub-module: fetch_inflight_cnt. It owns the saturating in-flight counter, imem_req_allow and the pend computation.

Test Plan:
- Branch, idle fetch: inflight = 0, mem_is_branch_jump = 1, branch_pc = 0x8000_0100 -> same cycle pc_redirect_valid = 1, target 0x8000_0100, cause 0, id_flush = ex_flush = 1; FSM stays RUN, no kill.
- Redirect with fetches in flight: inflight = 2, mret with mepc = 0x8000_0040 -> drop_cnt = 2, DRAIN. Next two imem_resp_valid pulses get if_kill = 1; third response not killed; FSM back in RUN.
- Priority: trap and branch together, trap_pc = 0x8000_0004 -> target 0x8000_0004, cause 3. mret and sret together -> cause 2 with mepc.
- Load-use vs flush: id_load_use alone -> if_stall = 1, ex_flush = 1, imem_req_allow = 0. id_load_use + sret in the same cycle -> if_stall = 0, id_flush = ex_flush = 1, redirect to sepc.
- Second redirect during DRAIN: drop_cnt = 1, new branch while inflight = 1 and a fetch fires -> drop_cnt reloads to 2. Exactly two more kills follow.
- Reset mid-DRAIN (drop_cnt = 2) and saturation: rst for 1 cycle -> RUN, counters 0, if_kill = 0 on the next response. MAX_INFLIGHT = 2 with inflight = 2 -> imem_req_allow = 0. A spurious response with inflight = 0 leaves the counter at 0.
